// File: rtl/dma_channel_arbiter.sv
// Four-channel DMA request arbiter: requests CPU bus hold, then grants one
// channel at a time with fixed or rotating priority.
module dma_channel_arbiter (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] DREQ,
    input  logic [3:0] requestReg,
    input  logic [3:0] maskReg,
    input  logic       priorityType,
    input  logic       HLDA,
    input  logic       serviceDone,
    output logic       HRQ,
    output logic [3:0] DACK,
    output logic [1:0] activeChannel,
    output logic       grantValid
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD_REQ = 2'd1,
        GRANT    = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] dack_q, dack_d;
    logic [1:0] active_q, active_d;
    logic [1:0] ptr_q, ptr_d;

    logic [3:0] eligible;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;

    assign eligible = (DREQ | requestReg) & ~maskReg;

    // Search starts at channel 0 in fixed mode, or at the pointer in rotating mode.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = priorityType ? ptr_q + 2'(i) : 2'(i);
            if (!found && eligible[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        dack_d   = dack_q;
        active_d = active_q;
        ptr_d    = ptr_q;
        case (state_q)
            IDLE: begin
                dack_d = 4'b0000;
                if (|eligible) state_d = HOLD_REQ;
            end
            HOLD_REQ: begin
                if (HLDA) begin
                    if (|eligible) begin
                        state_d  = GRANT;
                        active_d = winner;
                        dack_d   = 4'b0001 << winner;
                    end else begin
                        state_d = RELEASE;
                        dack_d  = 4'b0000;
                    end
                end
            end
            GRANT: begin
                // serviceDone wins over a simultaneous HLDA drop, so the pointer still advances.
                if (serviceDone) begin
                    state_d = RELEASE;
                    dack_d  = 4'b0000;
                    if (priorityType) ptr_d = active_q + 2'd1;
                end else if (!HLDA) begin
                    state_d = RELEASE;
                    dack_d  = 4'b0000;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                dack_d  = 4'b0000;
            end
            default: begin
                state_d = IDLE;
                dack_d  = 4'b0000;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            dack_q   <= 4'b0000;
            active_q <= 2'd0;
            ptr_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            dack_q   <= dack_d;
            active_q <= active_d;
            ptr_q    <= ptr_d;
        end
    end

    assign HRQ           = (state_q == HOLD_REQ) || (state_q == GRANT);
    assign DACK          = dack_q;
    assign activeChannel = active_q;
    assign grantValid    = |dack_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Self-checking bench for dma_channel_arbiter: table of full transactions plus
// hand sequences for withdrawal, re-request and asynchronous reset.
module tb_dma_channel_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] DREQ, requestReg, maskReg;
    logic       priorityType, HLDA, serviceDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic [1:0] activeChannel;
    logic       grantValid;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [3:0] dack;
        logic [1:0] chan;
    } exp_t;

    typedef struct packed {
        logic [3:0] dreq;
        logic [3:0] sreq;
        logic [3:0] mask;
        logic       ptype;
        logic       abort;
        logic [3:0] dack;
        logic [1:0] chan;
    } row_t;

    exp_t exp_q[$];
    row_t rows[16];
    logic gv_prev = 1'b0;

    dma_channel_arbiter dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .DREQ         (DREQ),
        .requestReg   (requestReg),
        .maskReg      (maskReg),
        .priorityType (priorityType),
        .HLDA         (HLDA),
        .serviceDone  (serviceDone),
        .HRQ          (HRQ),
        .DACK         (DACK),
        .activeChannel(activeChannel),
        .grantValid   (grantValid)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: each rising grantValid must match the oldest expected grant.
    always @(posedge CLK) begin
        #1;
        if (grantValid && !gv_prev) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_grant", {28'd0, DACK}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_dack", {28'd0, DACK}, {28'd0, e.dack});
                check("sb_chan", {30'd0, activeChannel}, {30'd0, e.chan});
            end
        end
        gv_prev = grantValid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic run_row(input row_t r);
        @(negedge CLK);
        DREQ = r.dreq; requestReg = r.sreq; maskReg = r.mask;
        priorityType = r.ptype; HLDA = 1'b0; serviceDone = 1'b0;
        #1;
        check("row_no_early_hrq", {31'd0, HRQ}, 32'd0);
        tick();
        check("row_hrq", {31'd0, HRQ}, 32'd1);
        tick();
        tick();
        check("row_hold_no_dack", {28'd0, DACK}, 32'd0);
        check("row_hold_hrq", {31'd0, HRQ}, 32'd1);
        @(negedge CLK);
        HLDA = 1'b1;
        exp_q.push_back('{dack: r.dack, chan: r.chan});
        tick();
        check("row_grant_latency", {31'd0, grantValid}, 32'd1);
        @(negedge CLK);
        DREQ = 4'd0; requestReg = 4'd0; maskReg = 4'hF; priorityType = ~r.ptype;
        tick();
        check("row_frozen", {28'd0, DACK}, {28'd0, r.dack});
        @(negedge CLK);
        priorityType = r.ptype; maskReg = 4'd0;
        if (r.abort) HLDA = 1'b0;
        else         serviceDone = 1'b1;
        tick();
        check("row_release_dack", {28'd0, DACK}, 32'd0);
        check("row_release_hrq", {31'd0, HRQ}, 32'd0);
        check("row_release_gv", {31'd0, grantValid}, 32'd0);
        @(negedge CLK);
        serviceDone = 1'b0; HLDA = 1'b0;
        tick();
        check("row_idle_hrq", {31'd0, HRQ}, 32'd0);
    endtask

    initial begin
        // dreq, sreq, mask, ptype, abort, dack, chan ; pointer starts at 0
        rows[0]  = '{4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0010, 2'd1};
        rows[1]  = '{4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1000, 2'd3};
        rows[2]  = '{4'b0001, 4'b0100, 4'b0001, 1'b0, 1'b0, 4'b0100, 2'd2};
        rows[3]  = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0001, 2'd0};
        rows[4]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0001, 2'd0}; // ptr -> 1
        rows[5]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0010, 2'd1}; // ptr -> 2
        rows[6]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0100, 2'd2}; // ptr -> 3
        rows[7]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1000, 2'd3}; // ptr -> 0
        rows[8]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0001, 2'd0}; // ptr -> 1
        rows[9]  = '{4'b0011, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0010, 2'd1}; // abort, ptr stays 1
        rows[10] = '{4'b0011, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0010, 2'd1}; // ptr -> 2
        rows[11] = '{4'b1100, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2}; // fixed, ptr stays 2
        rows[12] = '{4'b0011, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0001, 2'd0}; // wraps, ptr -> 1
        rows[13] = '{4'b1111, 4'b0000, 4'b0010, 1'b1, 1'b0, 4'b0100, 2'd2}; // pointer channel masked, ptr -> 3
        rows[14] = '{4'b1001, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1000, 2'd3}; // ptr -> 0
        rows[15] = '{4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0010, 2'd1}; // ptr -> 2

        RESET = 1'b1; DREQ = 4'd0; requestReg = 4'd0; maskReg = 4'd0;
        priorityType = 1'b0; HLDA = 1'b0; serviceDone = 1'b0;
        #1;
        check("reset_hrq", {31'd0, HRQ}, 32'd0);
        check("reset_dack", {28'd0, DACK}, 32'd0);
        check("reset_gv", {31'd0, grantValid}, 32'd0);
        check("reset_chan", {30'd0, activeChannel}, 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        tick();
        check("idle_no_req_hrq", {31'd0, HRQ}, 32'd0);

        for (int i = 0; i < 16; i++) run_row(rows[i]);

        // Request withdrawn before HLDA: release with no acknowledge, then idle.
        @(negedge CLK);
        DREQ = 4'b0100; priorityType = 1'b1; HLDA = 1'b0;
        tick();
        check("wd_hrq", {31'd0, HRQ}, 32'd1);
        @(negedge CLK);
        DREQ = 4'd0;
        tick();
        check("wd_hold_stays", {31'd0, HRQ}, 32'd1);
        @(negedge CLK);
        HLDA = 1'b1;
        tick();
        check("wd_release_hrq", {31'd0, HRQ}, 32'd0);
        check("wd_release_dack", {28'd0, DACK}, 32'd0);
        check("wd_release_gv", {31'd0, grantValid}, 32'd0);
        tick();
        check("wd_idle_hrq", {31'd0, HRQ}, 32'd0);
        @(negedge CLK);
        HLDA = 1'b0;
        tick();
        check("wd_idle2_hrq", {31'd0, HRQ}, 32'd0);

        // Fixed mode 1010: channel 1, one release cycle, then HRQ again for channel 3.
        @(negedge CLK);
        DREQ = 4'b1010; priorityType = 1'b0;
        tick();
        check("seq_hrq", {31'd0, HRQ}, 32'd1);
        tick();
        tick();
        @(negedge CLK);
        HLDA = 1'b1;
        exp_q.push_back('{dack: 4'b0010, chan: 2'd1});
        tick();
        check("seq_dack_ch1", {28'd0, DACK}, 32'b0010);
        @(negedge CLK);
        serviceDone = 1'b1; DREQ = 4'b1000;
        tick();
        check("seq_release_hrq", {31'd0, HRQ}, 32'd0);
        check("seq_release_dack", {28'd0, DACK}, 32'd0);
        @(negedge CLK);
        serviceDone = 1'b0; HLDA = 1'b0;
        tick();
        check("seq_idle_hrq", {31'd0, HRQ}, 32'd0);
        tick();
        check("seq_rehrq", {31'd0, HRQ}, 32'd1);
        @(negedge CLK);
        HLDA = 1'b1;
        exp_q.push_back('{dack: 4'b1000, chan: 2'd3});
        tick();
        check("seq_dack_ch3", {28'd0, DACK}, 32'b1000);

        // Asynchronous reset mid-GRANT; pointer was 2, so a rotating 1111 must pick channel 0.
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check("rst_mid_dack", {28'd0, DACK}, 32'd0);
        check("rst_mid_hrq", {31'd0, HRQ}, 32'd0);
        check("rst_mid_gv", {31'd0, grantValid}, 32'd0);
        check("rst_mid_chan", {30'd0, activeChannel}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0; DREQ = 4'b1111; priorityType = 1'b1; HLDA = 1'b0;
        tick();
        check("rst_after_hrq", {31'd0, HRQ}, 32'd1);
        @(negedge CLK);
        HLDA = 1'b1;
        exp_q.push_back('{dack: 4'b0001, chan: 2'd0});
        tick();
        check("rst_ptr_zero", {28'd0, DACK}, 32'b0001);
        @(negedge CLK);
        serviceDone = 1'b1;
        tick();
        @(negedge CLK);
        serviceDone = 1'b0; HLDA = 1'b0; DREQ = 4'd0;
        tick();
        tick();

        check("sb_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
